// File: rtl/sdram_arbiter.sv
// Two-port byte arbiter with internal auto-refresh scheduler in front of the Tang 20K SDRAM controller.
// Optional build macro SDRAM_ARB_ROUND_ROBIN_EN alternates A/B priority; default is fixed A-over-B.
module sdram_arbiter #(
  parameter int REFRESH_CYCLES = 1400,
  parameter int ADDR_WIDTH     = 23
) (
  input  logic                  clk,
  input  logic                  resetn,
  input  logic                  a_req,
  input  logic                  a_we,
  input  logic [ADDR_WIDTH-1:0] a_addr,
  input  logic [7:0]            a_wdata,
  output logic                  a_ack,
  output logic [7:0]            a_rdata,
  input  logic                  b_req,
  input  logic                  b_we,
  input  logic [ADDR_WIDTH-1:0] b_addr,
  input  logic [7:0]            b_wdata,
  output logic                  b_ack,
  output logic [7:0]            b_rdata,
  output logic                  mem_rd,
  output logic                  mem_wr,
  output logic                  mem_refresh,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [7:0]            mem_din,
  input  logic [7:0]            mem_dout,
  input  logic                  mem_data_ready,
  input  logic                  mem_busy,
  output logic                  refresh_overrun
);

  localparam int CNT_W = $clog2(REFRESH_CYCLES);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;
  typedef enum logic [1:0] {OWN_A, OWN_B, OWN_REF} owner_t;

  state_t           state, state_nxt;
  owner_t           owner;
  logic             owner_we;
  logic [CNT_W-1:0] ref_cnt;
  logic             ref_pend;
  logic             ref_tick;
  logic             ref_clr;
  logic             grant_ref, grant_a, grant_b;
  logic             prio_b;

  assign ref_tick = (ref_cnt == CNT_W'(REFRESH_CYCLES - 1));
  assign ref_clr  = (state == ISSUE) && (owner == OWN_REF);

  // Refresh tick generator; a tick that finds the previous one still pending is an overrun.
  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      ref_cnt         <= '0;
      ref_pend        <= 1'b0;
      refresh_overrun <= 1'b0;
    end else begin
      ref_cnt <= ref_tick ? '0 : ref_cnt + 1'b1;
      if (ref_tick) begin
        ref_pend <= 1'b1;
        if (ref_pend) refresh_overrun <= 1'b1;
      end else if (ref_clr) begin
        ref_pend <= 1'b0;
      end
    end
  end

`ifdef SDRAM_ARB_ROUND_ROBIN_EN
  // Whoever was served last yields the next contested grant.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn)      prio_b <= 1'b0;
    else if (grant_a) prio_b <= 1'b1;
    else if (grant_b) prio_b <= 1'b0;
  end
`else
  assign prio_b = 1'b0;
`endif

  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    grant_ref = 1'b0;
    grant_a   = 1'b0;
    grant_b   = 1'b0;
    if (state == IDLE && !mem_busy) begin
      if (ref_pend)                       grant_ref = 1'b1;
      else if (a_req && !(b_req && prio_b)) grant_a = 1'b1;
      else if (b_req)                     grant_b   = 1'b1;
    end
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (grant_ref || grant_a || grant_b) state_nxt = ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (!mem_busy) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // Command/data path. Address and write byte are only reloaded on a client grant,
  // so they stay stable across refreshes until the next client access.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      owner       <= OWN_A;
      owner_we    <= 1'b0;
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_refresh <= 1'b0;
      mem_addr    <= '0;
      mem_din     <= '0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;
      a_rdata     <= '0;
      b_rdata     <= '0;
    end else begin
      mem_rd      <= 1'b0;
      mem_wr      <= 1'b0;
      mem_refresh <= 1'b0;
      a_ack       <= 1'b0;
      b_ack       <= 1'b0;

      if (grant_ref) begin
        owner       <= OWN_REF;
        mem_refresh <= 1'b1;
      end else if (grant_a) begin
        owner    <= OWN_A;
        owner_we <= a_we;
        mem_addr <= a_addr;
        mem_din  <= a_wdata;
        mem_rd   <= !a_we;
        mem_wr   <= a_we;
      end else if (grant_b) begin
        owner    <= OWN_B;
        owner_we <= b_we;
        mem_addr <= b_addr;
        mem_din  <= b_wdata;
        mem_rd   <= !b_we;
        mem_wr   <= b_we;
      end

      if (state == WAIT) begin
        if (mem_data_ready && !owner_we) begin
          if (owner == OWN_A) a_rdata <= mem_dout;
          if (owner == OWN_B) b_rdata <= mem_dout;
        end
        if (!mem_busy) begin
          a_ack <= (owner == OWN_A);
          b_ack <= (owner == OWN_B);
        end
      end
    end
  end

endmodule

// File: tb/tb_sdram_arbiter.sv
// Directed bench for sdram_arbiter: small controller model, refresh-priority model, linear test steps.
module tb_sdram_arbiter;
  localparam int AW = 23;

  logic          clk = 1'b0;
  logic          resetn;
  logic          a_req, a_we, b_req, b_we;
  logic [AW-1:0] a_addr, b_addr;
  logic [7:0]    a_wdata, b_wdata;
  logic          a_ack, b_ack;
  logic [7:0]    a_rdata, b_rdata;
  logic          mem_rd, mem_wr, mem_refresh;
  logic [AW-1:0] mem_addr;
  logic [7:0]    mem_din;
  logic [7:0]    mem_dout = 8'h00;
  logic          mem_data_ready = 1'b0;
  logic          mem_busy = 1'b1;
  logic          refresh_overrun;

  always #5 clk = ~clk;

  sdram_arbiter #(.REFRESH_CYCLES(16), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .resetn(resetn),
    .a_req(a_req), .a_we(a_we), .a_addr(a_addr), .a_wdata(a_wdata), .a_ack(a_ack), .a_rdata(a_rdata),
    .b_req(b_req), .b_we(b_we), .b_addr(b_addr), .b_wdata(b_wdata), .b_ack(b_ack), .b_rdata(b_rdata),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .mem_refresh(mem_refresh), .mem_addr(mem_addr), .mem_din(mem_din),
    .mem_dout(mem_dout), .mem_data_ready(mem_data_ready), .mem_busy(mem_busy),
    .refresh_overrun(refresh_overrun)
  );

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  logic       hold_busy;
  logic [7:0] rd_val;

  // Controller model plus event monitor, evaluated on the falling edge.
  int            busy_cnt = 0;
  logic          rd_pend = 1'b0;
  int            n_rd = 0, n_wr = 0, n_ref = 0, n_aack = 0, n_back = 0;
  logic [AW-1:0] last_rd_addr = '0, last_wr_addr = '0;
  logic [7:0]    last_wr_din = '0;
  logic [AW-1:0] grant_q[$];
  // Refresh-pending model: a client may only be granted when no refresh was pending.
  int            tcnt = 0;
  logic          m_pend = 1'b0, pend_prev = 1'b0, prev_ref = 1'b0, prev_rstn = 1'b0;
  int            viol = 0;

  always @(negedge clk) begin
    mem_data_ready = 1'b0;
    if (!resetn) begin
      busy_cnt = 0;
      rd_pend  = 1'b0;
    end else if (mem_rd || mem_wr || mem_refresh) begin
      busy_cnt = 4;
      rd_pend  = mem_rd;
    end else if (busy_cnt != 0) begin
      busy_cnt--;
      if (busy_cnt == 1 && rd_pend) begin
        mem_data_ready = 1'b1;
        mem_dout       = rd_val;
      end
    end
    mem_busy = hold_busy || (busy_cnt != 0);

    if (mem_rd)      begin n_rd++; last_rd_addr = mem_addr; end
    if (mem_wr)      begin n_wr++; last_wr_addr = mem_addr; last_wr_din = mem_din; end
    if (mem_refresh) n_ref++;
    if (mem_rd || mem_wr) grant_q.push_back(mem_addr);
    if (a_ack) n_aack++;
    if (b_ack) n_back++;

    if (!resetn) begin
      tcnt = 0; m_pend = 1'b0; pend_prev = 1'b0; prev_ref = 1'b0;
    end else if (prev_rstn) begin
      pend_prev = m_pend;
      if (prev_ref) m_pend = 1'b0;
      if (tcnt == 15) begin tcnt = 0; m_pend = 1'b1; end
      else tcnt++;
      prev_ref = mem_refresh;
      if ((mem_rd || mem_wr) && pend_prev) viol++;
      if (mem_refresh && !pend_prev) viol++;
    end
    prev_rstn = resetn;
  end

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic wait_ack(input bit port_b, input int bound, output bit got);
    got = 1'b0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (port_b ? b_ack : a_ack) begin got = 1'b1; break; end
    end
  endtask

  task automatic wait_ref(input int bound, output int t, output bit got);
    got = 1'b0;
    t   = 0;
    for (int i = 0; i < bound; i++) begin
      tick();
      if (mem_refresh) begin got = 1'b1; t = cyc; break; end
    end
  endtask

  initial begin
    bit            got, g1, g2, g3;
    int            t1, t2, t3;
    int            base_rd, base_wr, base_ref, base_aack, base_back, gbase, vbase;
    logic [AW-1:0] exp_grant[4];

    resetn = 1'b0; hold_busy = 1'b1; rd_val = 8'h00;
    a_req = 1'b0; a_we = 1'b0; a_addr = '0; a_wdata = '0;
    b_req = 1'b0; b_we = 1'b0; b_addr = '0; b_wdata = '0;
    repeat (3) tick();

    // Reset state
    check("rst_cmds",    32'({mem_rd, mem_wr, mem_refresh}), 32'd0);
    check("rst_acks",    32'({a_ack, b_ack}), 32'd0);
    check("rst_mem_addr", 32'(mem_addr), 32'd0);
    check("rst_mem_din", 32'(mem_din), 32'd0);
    check("rst_rdata",   32'({a_rdata, b_rdata}), 32'd0);
    check("rst_overrun", 32'(refresh_overrun), 32'd0);

    // Controller init: busy held for 200 cycles with a read pending on A
    resetn = 1'b1;
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h012345; rd_val = 8'hA5;
    base_rd = n_rd; base_wr = n_wr; base_ref = n_ref; base_aack = n_aack;
    repeat (200) tick();
    check("init_no_cmd", 32'((n_rd - base_rd) + (n_wr - base_wr) + (n_ref - base_ref)), 32'd0);
    check("init_overrun", 32'(refresh_overrun), 32'd1);
    hold_busy = 1'b0;

    // Read on A completes after busy falls
    wait_ack(1'b0, 100, got);
    a_req = 1'b0;
    check("rd_ack_seen", 32'(got), 32'd1);
    check("rd_rdata_with_ack", 32'(a_rdata), 32'hA5);
    check("rd_one_cmd", 32'(n_rd - base_rd), 32'd1);
    check("rd_addr", 32'(last_rd_addr), 32'h012345);
    tick();
    check("rd_ack_pulse", 32'(a_ack), 32'd0);
    repeat (10) tick();
    check("rd_ack_count", 32'(n_aack - base_aack), 32'd1);
    check("rd_rdata_held", 32'(a_rdata), 32'hA5);
    check("rd_addr_stable", 32'(mem_addr), 32'h012345);
    check("rd_still_one", 32'(n_rd - base_rd), 32'd1);

    // Write on B at the top address
    base_wr = n_wr; base_back = n_back;
    b_req = 1'b1; b_we = 1'b1; b_addr = 23'h7FFFFF; b_wdata = 8'h3C;
    wait_ack(1'b1, 100, got);
    b_req = 1'b0;
    check("wr_ack_seen", 32'(got), 32'd1);
    check("wr_one_cmd", 32'(n_wr - base_wr), 32'd1);
    check("wr_addr", 32'(last_wr_addr), 32'h7FFFFF);
    check("wr_din", 32'(last_wr_din), 32'h3C);
    check("wr_b_rdata", 32'(b_rdata), 32'd0);
    check("wr_a_rdata", 32'(a_rdata), 32'hA5);
    repeat (5) tick();
    check("wr_ack_count", 32'(n_back - base_back), 32'd1);

    // Idle refresh cadence
    wait_ref(40, t1, g1);
    wait_ref(40, t2, g2);
    wait_ref(40, t3, g3);
    check("ref_seen", 32'({g1, g2, g3}), 32'b111);
    check("ref_period1", 32'(t2 - t1), 32'd16);
    check("ref_period2", 32'(t3 - t2), 32'd16);
    check("ref_overrun_sticky", 32'(refresh_overrun), 32'd1);

    // Contention: both ports request continuously
    gbase = grant_q.size(); vbase = viol; base_ref = n_ref;
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000100;
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000200; rd_val = 8'h11;
    for (int i = 0; i < 200; i++) begin
      tick();
      if (grant_q.size() - gbase >= 4) break;
    end
    a_req = 1'b0; b_req = 1'b0;
    check("cont_four_grants", 32'(grant_q.size() - gbase >= 4), 32'd1);
    repeat (20) tick();
    check("cont_no_extra", 32'(grant_q.size() - gbase), 32'd4);
`ifdef SDRAM_ARB_ROUND_ROBIN_EN
    exp_grant = '{23'h000100, 23'h000200, 23'h000100, 23'h000200};
`else
    exp_grant = '{23'h000100, 23'h000100, 23'h000100, 23'h000100};
`endif
    for (int i = 0; i < 4; i++)
      if (gbase + i < grant_q.size())
        check($sformatf("cont_grant%0d", i), 32'(grant_q[gbase + i]), 32'(exp_grant[i]));
    check("cont_refresh_served", 32'(n_ref - base_ref >= 1), 32'd1);
    check("cont_refresh_first", 32'(viol - vbase), 32'd0);

    // Asynchronous reset in the middle of a read
    a_req = 1'b1; a_we = 1'b0; a_addr = 23'h000ABC; rd_val = 8'h77;
    got = 1'b0;
    for (int i = 0; i < 100; i++) begin
      tick();
      if (mem_rd) begin got = 1'b1; break; end
    end
    check("mid_rd_issued", 32'(got), 32'd1);
    tick();
    tick();
    #2;
    resetn = 1'b0; hold_busy = 1'b1;
    #1;
    check("mid_cmds_zero", 32'({mem_rd, mem_wr, mem_refresh, a_ack, b_ack}), 32'd0);
    check("mid_addr_zero", 32'(mem_addr), 32'd0);
    check("mid_rdata_zero", 32'({a_rdata, b_rdata}), 32'd0);
    check("mid_overrun_zero", 32'(refresh_overrun), 32'd0);
    a_req = 1'b0;
    base_aack = n_aack;
    repeat (3) tick();
    resetn = 1'b1;

    // Busy held after reset: a cancelled B request and a fresh overrun
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000055;
    repeat (5) tick();
    b_req = 1'b0;
    gbase = grant_q.size();
    repeat (40) tick();
    check("post_overrun_set", 32'(refresh_overrun), 32'd1);
    hold_busy = 1'b0;
    repeat (30) tick();
    check("post_overrun_sticky", 32'(refresh_overrun), 32'd1);
    check("post_cancel_no_grant", 32'(grant_q.size() - gbase), 32'd0);
    check("post_no_stale_ack", 32'(n_aack - base_aack), 32'd0);

    // A new request after reset completes normally
    b_req = 1'b1; b_we = 1'b0; b_addr = 23'h000055; rd_val = 8'h5A;
    wait_ack(1'b1, 100, got);
    b_req = 1'b0;
    check("post_ack_seen", 32'(got), 32'd1);
    check("post_b_rdata", 32'(b_rdata), 32'h5A);
    check("post_mem_addr", 32'(mem_addr), 32'h000055);
    check("post_a_rdata", 32'(a_rdata), 32'd0);
    check("refresh_priority_all", 32'(viol), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/sdram_arbiter.md
# sdram_arbiter

Request arbiter and refresh scheduler that sits directly upstream of the Tang 20K byte-wide SDRAM controller. Multiplexes two byte-access client ports (A and B) and a periodic auto-refresh onto the controller's single rd/wr/refresh command interface. Each client gets a req/ack handshake with a held read-data register. Refresh is generated internally so clients never see refresh timing.

## Interface
Parameters:
- `REFRESH_CYCLES`, 1400: clk cycles between refresh ticks (≈14.6 µs at 96 MHz); must be ≥ 16.
- `ADDR_WIDTH`, 23: byte address width.

Ports:
- `clk`  in  1  system clock, same clock as the controller.
- `resetn`  in  1  asynchronous, active-low reset.
- `a_req`  in  1  port A request, level; held until `a_ack`.
- `a_we`  in  1  port A write (1) / read (0).
- `a_addr`  in  ADDR_WIDTH  port A byte address.
- `a_wdata`  in  8  port A write byte.
- `a_ack`  out  1  port A completion pulse, one cycle.
- `a_rdata`  out  8  port A read byte, held.
- `b_req`, `b_we`, `b_addr`, `b_wdata`, `b_ack`, `b_rdata`: identical set for port B.
- `mem_rd`  out  1  read command pulse to controller.
- `mem_wr`  out  1  write command pulse to controller.
- `mem_refresh`  out  1  auto-refresh command pulse to controller.
- `mem_addr`  out  ADDR_WIDTH  byte address to controller.
- `mem_din`  out  8  write byte to controller.
- `mem_dout`  in  8  read byte from controller.
- `mem_data_ready`  in  1  controller read-data strobe.
- `mem_busy`  in  1  controller busy; 1 through its init/config.
- `refresh_overrun`  out  1  sticky: a refresh tick arrived while the previous one was still pending.

## Operation
- Reset values: all outputs 0; state IDLE; refresh counter 0; refresh pending 0; priority pointer to A.
- Refresh counter: free-running, counts 0..REFRESH_CYCLES-1 and wraps. A wrap sets `ref_pend`. If `ref_pend` is already 1 at the wrap, `refresh_overrun` is set and stays set until reset.
- States: IDLE, ISSUE, WAIT.
- IDLE: when `mem_busy`=0, grant by priority: `ref_pend` first, then port A over port B. On a grant, register `mem_addr`, `mem_din` and the command, record the owner, and go to ISSUE. With nothing to grant, or with `mem_busy`=1, remain in IDLE.
- ISSUE: exactly one of `mem_rd`/`mem_wr`/`mem_refresh` is 1 for this single cycle. Go to WAIT. A refresh grant clears `ref_pend`.
- WAIT: if `mem_data_ready`=1 and the owner is a read, capture `mem_dout` into the owner's rdata. When `mem_busy`=0, pulse the owner's ack (no ack for refresh) and go to IDLE.
- `mem_addr`/`mem_din` stay stable from ISSUE until the next grant.
- Client rules:
  - Address, we and wdata must be stable while req=1.
  - Dropping req before grant cancels the request.
  - Dropping req after grant does not abort: the access completes and ack still pulses.
- Simultaneous events:
  - A refresh tick in the same cycle as a client grant leaves `ref_pend` set; the refresh is served next.
  - `a_req` and `b_req` together: A wins.

## Timing
- Grant decided in IDLE cycle N; command pulse in cycle N+1; WAIT from N+2. The controller's registered busy is already 1 at N+2.
- ack is asserted the cycle after `mem_busy` is first seen 0 in WAIT.
- rdata updates on the edge after `mem_data_ready`, i.e. before or with ack. rdata holds until that port's next read completes.
- Back-to-back: the next grant can be decided in the cycle ack is high, so there is a minimum 1-cycle IDLE gap between commands.
- Asynchronous reset mid-access:
  - Drops command pulses immediately.
  - No ack is issued.
  - Controller recovery is the controller's own reset's job.

## Configuration
- `SDRAM_ARB_ROUND_ROBIN_EN`:
  - Defined: A/B priority alternates. After serving A, B has priority on the next contested grant, and vice versa. Refresh still has top priority.
  - Undefined: fixed priority, A over B; B can starve under continuous `a_req`.

## Test plan
- Init: hold `mem_busy`=1 for 200 cycles with `a_req`=1 -> no `mem_rd`/`mem_wr` until busy falls; then exactly one `mem_rd` pulse.
- Read: `a_req`=1, `a_we`=0, `a_addr`=0x012345; model returns 0xA5 on `mem_data_ready` -> `mem_addr`=0x012345, one `mem_rd` pulse, `a_ack` single pulse, `a_rdata`=0xA5 held afterwards.
- Write: `b_req`=1, `b_we`=1, `b_addr`=0x7FFFFF, `b_wdata`=0x3C -> one `mem_wr` pulse with `mem_din`=0x3C and `mem_addr`=0x7FFFFF, `b_ack` after busy falls, `b_rdata` unchanged.
- Refresh: `REFRESH_CYCLES`=16, no client traffic -> `mem_refresh` pulses every 16 cycles; hold `mem_busy`=1 for 40 cycles -> `refresh_overrun`=1, sticky.
- Contention: `a_req`=`b_req`=1 continuously for 4 accesses -> without the macro, grants A,A,A,A; with `SDRAM_ARB_ROUND_ROBIN_EN`, grants A,B,A,B; a coincident refresh tick is served before the next client grant.
- Reset mid-access: assert `resetn`=0 during WAIT -> all outputs 0 asynchronously, no ack; after release, a new request completes normally.
